// File: rtl/int_to_float.sv
// -----------------------------------------------------------------------------
// int_to_float
//
// Converts one integer at a time into a binary floating-point value with
// EXP_BITS exponent bits and MANT_BITS stored mantissa bits. The result is
// rounded to nearest, ties to even. Values too large for the format become
// signed infinity.
//
// A nonzero input is normalised by shifting one bit per clock. It then takes
// one rounding cycle before the result is presented.
//
// Handshake rules:
//   - An input transfer happens on a rising edge where in_valid && in_ready.
//   - An output transfer happens on a rising edge where out_valid && out_ready.
//   - in_ready is high only in IDLE.
//   - out_valid is high only in DONE.
//   - out_data is held stable from the time out_valid rises until the
//     output transfer.
//   - The block returns to IDLE on the output-transfer edge. It can accept
//     the next input on the following edge at the earliest.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset; aborts any conversion
//   in_valid     in_data is valid
//   in_ready     block can accept a new integer (IDLE)
//   in_data      integer to convert (two's complement when SIGNED != 0)
//   out_valid    out_data holds a completed result (DONE)
//   out_ready    consumer accepts out_data
//   out_data     {sign, exponent, mantissa}
//   dbg_state_o  current FSM state: 0 IDLE, 1 NORM, 2 ROUND, 3 DONE
// -----------------------------------------------------------------------------
module int_to_float #(
    parameter int INT_BITS  = 32,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 23,
    parameter int SIGNED    = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INT_BITS-1:0]             in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_BITS+MANT_BITS:0]     out_data,
    output logic [1:0]                      dbg_state_o
);

    localparam int OW   = 1 + EXP_BITS + MANT_BITS;
    // Wide enough for BIAS + INT_BITS - 1 + carry for every legal parameter mix.
    localparam int XW   = EXP_BITS + 8;
    localparam int SCW  = $clog2(INT_BITS);
    localparam int BIAS = (1 << (EXP_BITS - 1)) - 1;
    // Fraction bits below the hidden one, padded so that the mantissa,
    // the guard bit and at least one sticky bit always exist.
    localparam int EXTW = INT_BITS + MANT_BITS + 1;

    localparam logic [XW-1:0] EXP_INIT = XW'(BIAS + INT_BITS - 1);
    localparam logic [XW-1:0] EXP_INF  = XW'((1 << EXP_BITS) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [INT_BITS-1:0] mag_q, mag_d;
    logic [SCW-1:0]      shift_cnt_q, shift_cnt_d;
    logic [XW-1:0]       exp_q, exp_d;
    logic                sign_q, sign_d;
    logic [OW-1:0]       out_q, out_d;

    // ---------------------------------------------------------------------
    // Input decode: sign and magnitude. The most negative value negates to
    // 2^(INT_BITS-1), which still fits as an unsigned INT_BITS value.
    // ---------------------------------------------------------------------
    logic                in_sign;
    logic [INT_BITS-1:0] in_mag;
    logic                in_zero;

    always_comb begin
        in_sign = (SIGNED != 0) ? in_data[INT_BITS-1] : 1'b0;
        in_mag  = in_sign ? ((~in_data) + INT_BITS'(1)) : in_data;
        in_zero = (in_mag == '0);
    end

    // ---------------------------------------------------------------------
    // Rounding datapath. It operates on the normalised magnitude, whose MSB
    // is the hidden one.
    // ---------------------------------------------------------------------
    logic [EXTW-1:0]      frac_ext;
    logic [MANT_BITS-1:0] man_raw;
    logic                 guard_bit;
    logic                 sticky_bit;
    logic                 round_up;
    logic [MANT_BITS:0]   man_sum;
    logic [XW-1:0]        exp_rnd;
    logic                 overflow;
    logic [EXP_BITS-1:0]  exp_field;
    logic [MANT_BITS-1:0] man_field;

    always_comb begin
        frac_ext   = {mag_q[INT_BITS-2:0], {(MANT_BITS + 2){1'b0}}};
        man_raw    = frac_ext[EXTW-1 -: MANT_BITS];
        guard_bit  = frac_ext[EXTW-1-MANT_BITS];
        sticky_bit = |frac_ext[EXTW-2-MANT_BITS:0];
        round_up   = guard_bit & (sticky_bit | man_raw[0]);
        // A carry out of the mantissa leaves the low bits at zero and bumps the exponent.
        man_sum    = {1'b0, man_raw} + (MANT_BITS + 1)'(round_up);
        exp_rnd    = exp_q + XW'(man_sum[MANT_BITS]);
        overflow   = (exp_rnd >= EXP_INF);
        exp_field  = overflow ? {EXP_BITS{1'b1}} : exp_rnd[EXP_BITS-1:0];
        man_field  = overflow ? '0 : man_sum[MANT_BITS-1:0];
    end

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_zero ? S_DONE : S_NORM;
                end
            end
            S_NORM: begin
                if (mag_q[INT_BITS-1]) begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: state_d = S_DONE;
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready    = (state_q == S_IDLE) && rst_n;
        out_valid   = (state_q == S_DONE);
        out_data    = out_q;
        dbg_state_o = state_q;
    end

    // ---------------------------------------------------------------------
    // Datapath next-state
    // ---------------------------------------------------------------------
    always_comb begin
        mag_d       = mag_q;
        shift_cnt_d = shift_cnt_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        out_d       = out_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mag_d       = in_mag;
                    shift_cnt_d = '0;
                    exp_d       = EXP_INIT;
                    // Zero converts to +0; a negative sign never reaches it.
                    sign_d      = in_sign & ~in_zero;
                    if (in_zero) begin
                        out_d = '0;
                    end
                end
            end
            S_NORM: begin
                if (!mag_q[INT_BITS-1]) begin
                    mag_d       = mag_q << 1;
                    shift_cnt_d = shift_cnt_q + SCW'(1);
                    exp_d       = exp_q - XW'(1);
                end
            end
            S_ROUND: begin
                out_d = {sign_q, exp_field, man_field};
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q       <= '0;
            shift_cnt_q <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            out_q       <= '0;
        end else begin
            mag_q       <= mag_d;
            shift_cnt_q <= shift_cnt_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// -----------------------------------------------------------------------------
// tb_int_to_float
//
// Bench for int_to_float. It uses two instances that share the clock and the
// reset:
//   - dut    : default 32-bit integer input to a 32-bit float output
//   - dut_h  : 32-bit integer input to a 16-bit float output
//              (EXP_BITS=5, MANT_BITS=10)
//
// Expected results come from a fixed vector table and from a reference model.
// The model builds the float by locating the leading one, then rounding the
// integer quotient mag / 2^shift using its remainder.
// -----------------------------------------------------------------------------
module tb_int_to_float;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT (defaults) ----------------
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  dbg_state;

    int_to_float dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .dbg_state_o(dbg_state)
    );

    // ---------------- DUT (half-precision output) ----------------
    logic        h_in_valid;
    logic        h_in_ready;
    logic [31:0] h_in_data;
    logic        h_out_valid;
    logic        h_out_ready;
    logic [15:0] h_out_data;
    logic [1:0]  h_dbg_state;

    int_to_float #(
        .INT_BITS (32),
        .EXP_BITS (5),
        .MANT_BITS(10),
        .SIGNED   (1)
    ) dut_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (h_in_valid),
        .in_ready   (h_in_ready),
        .in_data    (h_in_data),
        .out_valid  (h_out_valid),
        .out_ready  (h_out_ready),
        .out_data   (h_out_data),
        .dbg_state_o(h_dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_float(input logic [63:0] val, input int nbits,
                                              input int eb, input int mb, input bit is_signed);
        logic [63:0] v, mag, q, rem, half, frac;
        bit s;
        int p, e, shift;
        v = val & ((64'd1 << nbits) - 64'd1);
        s = is_signed && v[nbits-1];
        mag = s ? ((64'd1 << nbits) - v) : v;
        if (mag == 64'd0) return 64'd0;
        p = 63;
        while (!mag[p]) p--;
        e = p + (1 << (eb - 1)) - 1;
        if (p <= mb) begin
            frac = (mag - (64'd1 << p)) << (mb - p);
        end else begin
            shift = p - mb;
            q    = mag >> shift;
            rem  = mag & ((64'd1 << shift) - 64'd1);
            half = 64'd1 << (shift - 1);
            if (rem > half || (rem == half && q[0])) q = q + 64'd1;
            if (q == (64'd1 << (mb + 1))) begin
                q = q >> 1;
                e = e + 1;
            end
            frac = q - (64'd1 << mb);
        end
        if (e >= (1 << eb) - 1) begin
            e    = (1 << eb) - 1;
            frac = 64'd0;
        end
        return (64'(s) << (eb + mb)) | (64'(e) << mb) | frac;
    endfunction

    // Cycles from the transfer edge until out_valid is seen. Zero goes straight
    // to DONE, so it is visible right after the transfer edge. A nonzero value
    // needs leading-zeros + 2 edges.
    function automatic int ref_lat(input logic [31:0] din);
        logic [31:0] mag;
        int p;
        mag = din[31] ? (32'd0 - din) : din;
        if (mag == 32'd0) return 0;
        p = 31;
        while (!mag[p]) p--;
        return (31 - p) + 2;
    endfunction

    // ---------------- scoreboard monitor ----------------
    // A handshake is seen at the negedge before the edge that completes it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("out_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send32(input logic [31:0] din, input logic [31:0] expv,
                          input int exp_lat, input int hold);
        int n;
        int lat;
        logic [31:0] held;
        bit stable;
        exp_q.push_back(expv);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'd0, 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_data  = din;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        if (!out_valid) return;
        held   = out_data;
        stable = 1'b1;
        // Stall the consumer while offering junk inputs that must be ignored.
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk);
            #1;
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", 64'(stable), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_after_handshake", {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    task automatic send16(input logic [31:0] din, input logic [15:0] expv);
        int n;
        @(negedge clk);
        n = 0;
        while (!h_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        h_in_valid = 1'b1;
        h_in_data  = din;
        @(posedge clk);
        #1;
        h_in_valid = 1'b0;
        n = 0;
        while (!h_out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("h_out_data", {48'd0, h_out_data}, {48'd0, expv});
        h_out_ready = 1'b1;
        @(posedge clk);
        #1;
        h_out_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] din;
        logic [31:0] expv;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] r;
        logic [63:0] m;
        bit          quiet;

        vecs[0] = '{32'h0000_0001, 32'h3F80_0000, 33};
        vecs[1] = '{32'hFFFF_FFFF, 32'hBF80_0000, 33};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000, 0};
        vecs[3] = '{32'h8000_0000, 32'hCF00_0000, 2};
        vecs[4] = '{32'd16777217,  32'h4B80_0000, 9};
        vecs[5] = '{32'd16777219,  32'h4B80_0002, 9};
        vecs[6] = '{32'h7FFF_FFFF, 32'h4F00_0000, 3};
        vecs[7] = '{32'h0000_0003, 32'h4040_0000, 32};
        vecs[8] = '{32'h7FFF_FFC0, 32'h4F00_0000, 3};

        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        h_in_valid  = 1'b0;
        h_in_data   = '0;
        h_out_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", {32'd0, out_data}, 64'd0);

        // Directed table
        foreach (vecs[i]) send32(vecs[i].din, vecs[i].expv, vecs[i].lat, (i == 1) ? 10 : 0);

        // Half-precision corners, then random values against the model
        send16(32'd65520, 16'h7C00);
        send16(-32'sd65504, 16'hFBFF);
        for (int i = 0; i < 8; i++) begin
            r = 32'($urandom_range(0, 200000));
            if ($urandom_range(0, 1) == 1) r = 32'd0 - r;
            m = ref_float({32'd0, r}, 32, 5, 10, 1'b1);
            send16(r, m[15:0]);
        end

        // Abort a conversion mid-normalisation
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_in_norm", 64'(dbg_state), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", {32'd0, out_data}, 64'd0);
        check("abort_state_idle", 64'(dbg_state), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) quiet = 1'b0;
        end
        check("abort_no_output", 64'(quiet), 64'd1);
        send32(32'd3, 32'h4040_0000, 32, 0);

        // Random 32-bit stimulus with a spread of leading-zero counts
        for (int i = 0; i < 30; i++) begin
            r = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 2) == 0) r = 32'd0 - r;
            m = ref_float({32'd0, r}, 32, 8, 23, 1'b1);
            send32(r, m[31:0], ref_lat(r), $urandom_range(0, 3));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
